// File: rtl/hazard_ctrl.sv
// Pipeline hazard control for the 5-stage core: RAW stall detection against in-flight
// writers, branch squash, halt drain sequencing and a saturating stall counter.
module hazard_ctrl #(
  parameter bit CHECK_WB     = 1'b0,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_rs_valid,
  input  logic [2:0]       id_rs,
  input  logic             id_rt_valid,
  input  logic [2:0]       id_rt,
  input  logic             id_wr_en,
  input  logic [2:0]       id_wr_reg,
  input  logic             id_halt,
  input  logic             ex_redirect,
  input  logic             mem_stall,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pc_redirect,
  output logic             halt_done,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} ctrlState;

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

  ctrlState         state, stateNext;
  logic [DCW-1:0]   drainCnt, drainCntNext;
  logic             exValid, memValid, wbValid;
  logic [2:0]       exReg, memReg, wbReg;
  logic [CNT_W-1:0] stallCntQ;

  logic rsHit, rtHit, raw, haltAccept, countStall, exLoad;

  assign rsHit = (exValid && exReg == id_rs) || (memValid && memReg == id_rs) ||
                 (CHECK_WB && wbValid && wbReg == id_rs);
  assign rtHit = (exValid && exReg == id_rt) || (memValid && memReg == id_rt) ||
                 (CHECK_WB && wbValid && wbReg == id_rt);

  assign raw = id_valid && (state == RUN) &&
               ((id_rs_valid && rsHit) || (id_rt_valid && rtHit));

  // A redirect or memory stall outranks both the RAW stall and halt acceptance.
  assign haltAccept = (state == RUN) && id_valid && id_halt && !raw && !ex_redirect && !mem_stall;
  assign countStall = raw && !ex_redirect && !mem_stall;
  assign exLoad     = id_valid && id_wr_en && !raw && !ex_redirect && (state == RUN);

  // NOTE: every variable in a combinational block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    stateNext    = state;
    drainCntNext = drainCnt;
    case (state)
      RUN: begin
        if (haltAccept) begin
          stateNext    = DRAIN;
          drainCntNext = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (!mem_stall) begin
          if (ex_redirect)          stateNext    = RUN;
          else if (drainCnt == '0)  stateNext    = HALTED;
          else                      drainCntNext = drainCnt - DCW'(1);
        end
      end
      HALTED:  stateNext = HALTED;
      default: stateNext = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      drainCnt  <= '0;
      // NOTE: the register indices are reset along with the valid bits; only the valid
      // bits are functionally required, but this keeps the scoreboard free of X.
      exValid   <= 1'b0;
      memValid  <= 1'b0;
      wbValid   <= 1'b0;
      exReg     <= '0;
      memReg    <= '0;
      wbReg     <= '0;
      stallCntQ <= '0;
    end else begin
      state    <= stateNext;
      drainCnt <= drainCntNext;
      if (!mem_stall) begin
        wbValid  <= memValid;
        wbReg    <= memReg;
        memValid <= exValid;
        memReg   <= exReg;
        exValid  <= exLoad;
        exReg    <= id_wr_reg;
      end
      if (countStall && stallCntQ != '1) stallCntQ <= stallCntQ + CNT_W'(1);
    end
  end

  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pc_redirect = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        pc_hold   = 1'b1;
        ifid_hold = 1'b1;
      end else if (state == HALTED) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end else if (ex_redirect) begin
        pc_redirect = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (raw || state == DRAIN) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end
    end
  end

  assign halt_done = !rst && (state == HALTED);
  assign stall_cnt = rst ? '0 : stallCntQ;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver pushes hand-computed expectations per
// cycle, a monitor pops and compares on the falling edge. dut1 adds WB compare and a 2-bit counter.
module tb_hazard_ctrl;

  localparam logic [5:0] E_IDLE  = 6'b000000;
  localparam logic [5:0] E_STALL = 6'b110100;
  localparam logic [5:0] E_MEM   = 6'b110000;
  localparam logic [5:0] E_REDIR = 6'b001110;
  localparam logic [5:0] E_HALT  = 6'b110101;

  typedef struct {
    string       tag;
    logic        sel;
    logic [5:0]  flags;
    logic [15:0] cnt;
  } expEntry;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic idValid0 = 1'b0, idValid1 = 1'b0;
  logic idRsValid = 1'b0, idRtValid = 1'b0, idWrEn = 1'b0, idHalt = 1'b0;
  logic [2:0] idRs = '0, idRt = '0, idWrReg = '0;
  logic exRedirect = 1'b0, memStall = 1'b0;

  logic pcHold0, ifidHold0, ifidFlush0, idexBubble0, pcRedirect0, haltDone0;
  logic pcHold1, ifidHold1, ifidFlush1, idexBubble1, pcRedirect1, haltDone1;
  logic [15:0] stallCnt0;
  logic [1:0]  stallCnt1;

  expEntry sbQ[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CHECK_WB(1'b0), .DRAIN_CYCLES(3), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .id_valid(idValid0), .id_rs_valid(idRsValid), .id_rs(idRs),
    .id_rt_valid(idRtValid), .id_rt(idRt), .id_wr_en(idWrEn), .id_wr_reg(idWrReg),
    .id_halt(idHalt), .ex_redirect(exRedirect), .mem_stall(memStall),
    .pc_hold(pcHold0), .ifid_hold(ifidHold0), .ifid_flush(ifidFlush0),
    .idex_bubble(idexBubble0), .pc_redirect(pcRedirect0), .halt_done(haltDone0),
    .stall_cnt(stallCnt0)
  );

  hazard_ctrl #(.CHECK_WB(1'b1), .DRAIN_CYCLES(3), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .id_valid(idValid1), .id_rs_valid(idRsValid), .id_rs(idRs),
    .id_rt_valid(idRtValid), .id_rt(idRt), .id_wr_en(idWrEn), .id_wr_reg(idWrReg),
    .id_halt(idHalt), .ex_redirect(exRedirect), .mem_stall(memStall),
    .pc_hold(pcHold1), .ifid_hold(ifidHold1), .ifid_flush(ifidFlush1),
    .idex_bubble(idexBubble1), .pc_redirect(pcRedirect1), .halt_done(haltDone1),
    .stall_cnt(stallCnt1)
  );

  task automatic check(input string tag, input string what, input logic [15:0] got,
                       input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h", tag, what, got, want);
    end
  endtask

  // Monitor: outputs are combinational, so one expectation is consumed per cycle.
  initial begin
    expEntry e;
    logic [5:0]  gotFlags;
    logic [15:0] gotCnt;
    forever begin
      @(negedge clk);
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        if (e.sel) begin
          gotFlags = {pcHold1, ifidHold1, ifidFlush1, idexBubble1, pcRedirect1, haltDone1};
          gotCnt   = {14'b0, stallCnt1};
        end else begin
          gotFlags = {pcHold0, ifidHold0, ifidFlush0, idexBubble0, pcRedirect0, haltDone0};
          gotCnt   = stallCnt0;
        end
        check(e.tag, "flags", {10'b0, gotFlags}, {10'b0, e.flags});
        check(e.tag, "stall_cnt", gotCnt, e.cnt);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input string tag, input logic sel, r, v, rsv, input logic [2:0] rs,
                      input logic rtv, input logic [2:0] rt, input logic we,
                      input logic [2:0] wr, input logic h, red, ms,
                      input logic [5:0] ef, input logic [15:0] ec);
    expEntry e;
    rst        = r;
    idValid0   = sel ? 1'b0 : v;
    idValid1   = sel ? v : 1'b0;
    idRsValid  = rsv;
    idRs       = rs;
    idRtValid  = rtv;
    idRt       = rt;
    idWrEn     = we;
    idWrReg    = wr;
    idHalt     = h;
    exRedirect = red;
    memStall   = ms;
    e.tag   = tag;
    e.sel   = sel;
    e.flags = ef;
    e.cnt   = ec;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic sel, input logic [5:0] ef,
                      input logic [15:0] ec);
    step(tag, sel, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, ef, ec);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset gating and idle
    step("rst_idle",  0, 1, 0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, E_IDLE, 0);
    step("rst_masks", 0, 1, 1, 1, 3'd1, 0, 3'd0, 1, 3'd1, 0, 1, 1, E_IDLE, 0);
    for (int i = 0; i < 3; i++) idle("idle_after_rst", 0, E_IDLE, 0);

    // RAW on EX then MEM writer, WB not compared
    step("wr_r3",   0, 0, 1, 1, 3'd1, 1, 3'd2, 1, 3'd3, 0, 0, 0, E_IDLE, 0);
    step("raw_ex",  0, 0, 1, 1, 3'd3, 1, 3'd4, 1, 3'd5, 0, 0, 0, E_STALL, 0);
    step("raw_mem", 0, 0, 1, 1, 3'd3, 1, 3'd4, 1, 3'd5, 0, 0, 0, E_STALL, 1);
    step("raw_go",  0, 0, 1, 1, 3'd3, 1, 3'd4, 1, 3'd5, 0, 0, 0, E_IDLE, 2);
    for (int i = 0; i < 3; i++) idle("idle_b", 0, E_IDLE, 2);

    // WB compare enabled: three stall cycles, then counter saturation at 2 bits
    step("wb_wr_r3",   1, 0, 1, 1, 3'd1, 1, 3'd2, 1, 3'd3, 0, 0, 0, E_IDLE, 0);
    step("wb_raw_ex",  1, 0, 1, 1, 3'd3, 1, 3'd4, 0, 3'd0, 0, 0, 0, E_STALL, 0);
    step("wb_raw_mem", 1, 0, 1, 1, 3'd3, 1, 3'd4, 0, 3'd0, 0, 0, 0, E_STALL, 1);
    step("wb_raw_wb",  1, 0, 1, 1, 3'd3, 1, 3'd4, 0, 3'd0, 0, 0, 0, E_STALL, 2);
    step("wb_go",      1, 0, 1, 1, 3'd3, 1, 3'd4, 0, 3'd0, 0, 0, 0, E_IDLE, 3);
    for (int i = 0; i < 2; i++) idle("wb_idle", 1, E_IDLE, 3);
    step("wb_wr_r7",   1, 0, 1, 1, 3'd1, 0, 3'd0, 1, 3'd7, 0, 0, 0, E_IDLE, 3);
    step("sat_stall1", 1, 0, 1, 0, 3'd0, 1, 3'd7, 0, 3'd0, 0, 0, 0, E_STALL, 3);
    step("sat_stall2", 1, 0, 1, 0, 3'd0, 1, 3'd7, 0, 3'd0, 0, 0, 0, E_STALL, 3);
    step("sat_stall3", 1, 0, 1, 0, 3'd0, 1, 3'd7, 0, 3'd0, 0, 0, 0, E_STALL, 3);
    step("sat_go",     1, 0, 1, 0, 3'd0, 1, 3'd7, 0, 3'd0, 0, 0, 0, E_IDLE, 3);
    idle("idle_c", 0, E_IDLE, 2);

    // R0 is tracked; redirect overrides RAW (uncounted) and squashes HALT
    step("wr_r0",         0, 0, 1, 1, 3'd1, 0, 3'd0, 1, 3'd0, 0, 0, 0, E_IDLE, 2);
    step("raw_r0",        0, 0, 1, 1, 3'd6, 1, 3'd0, 0, 3'd0, 0, 0, 0, E_STALL, 2);
    step("raw_redir",     0, 0, 1, 1, 3'd6, 1, 3'd0, 0, 3'd0, 0, 1, 0, E_REDIR, 3);
    idle("cnt_not_bumped", 0, E_IDLE, 3);
    step("halt_redir",    0, 0, 1, 0, 3'd0, 0, 3'd0, 0, 3'd0, 1, 1, 0, E_REDIR, 3);
    idle("halt_squashed", 0, E_IDLE, 3);
    idle("idle_d", 0, E_IDLE, 3);

    // mem_stall freezes the scoreboard and masks a held redirect
    step("wr_r5", 0, 0, 1, 1, 3'd1, 0, 3'd0, 1, 3'd5, 0, 0, 0, E_IDLE, 3);
    for (int i = 0; i < 4; i++)
      step("mstall", 0, 0, 1, 1, 3'd5, 0, 3'd0, 0, 3'd0, 0, 1, 1, E_MEM, 3);
    step("redir_after_stall", 0, 0, 1, 1, 3'd5, 0, 3'd0, 0, 3'd0, 0, 1, 0, E_REDIR, 3);
    step("frozen_mem_hit",    0, 0, 1, 1, 3'd5, 0, 3'd0, 0, 3'd0, 0, 0, 0, E_STALL, 3);
    step("raw_clear",         0, 0, 1, 1, 3'd5, 0, 3'd0, 0, 3'd0, 0, 0, 0, E_IDLE, 4);
    idle("idle_e", 0, E_IDLE, 4);

    // Halt drain with two mem_stall cycles inserted
    step("halt_in",   0, 0, 1, 0, 3'd0, 0, 3'd0, 0, 3'd0, 1, 0, 0, E_IDLE, 4);
    idle("drain1", 0, E_STALL, 4);
    step("drain_ms1", 0, 0, 0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1, E_MEM, 4);
    step("drain_ms2", 0, 0, 0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1, E_MEM, 4);
    idle("drain2", 0, E_STALL, 4);
    idle("drain3", 0, E_STALL, 4);
    idle("halted", 0, E_HALT, 4);
    step("halted_sticky", 0, 0, 1, 0, 3'd0, 0, 3'd0, 0, 3'd0, 1, 0, 0, E_HALT, 4);
    idle("halted_sticky2", 0, E_HALT, 4);

    // Wrong-path halt cancelled by redirect, then reset during a RAW stall
    step("rst_halted", 0, 1, 0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, E_IDLE, 0);
    idle("post_rst", 0, E_IDLE, 0);
    step("halt_in2",    0, 0, 1, 0, 3'd0, 0, 3'd0, 0, 3'd0, 1, 0, 0, E_IDLE, 0);
    step("drain_redir", 0, 0, 0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 0, E_REDIR, 0);
    idle("run_again", 0, E_IDLE, 0);
    step("wr_r2",        0, 0, 1, 1, 3'd1, 0, 3'd0, 1, 3'd2, 0, 0, 0, E_IDLE, 0);
    step("raw_r2",       0, 0, 1, 1, 3'd2, 0, 3'd0, 0, 3'd0, 0, 0, 0, E_STALL, 0);
    step("rst_in_raw",   0, 1, 1, 1, 3'd2, 0, 3'd0, 0, 3'd0, 0, 0, 0, E_IDLE, 0);
    step("post_rst_raw", 0, 0, 1, 1, 3'd2, 0, 3'd0, 0, 3'd0, 0, 0, 0, E_IDLE, 0);
    idle("final_idle", 0, E_IDLE, 0);

    for (int i = 0; i < 10 && sbQ.size() > 0; i++) @(negedge clk);
    if (sbQ.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
